// File: rtl/mp_add_sequencer.sv
// Multi-precision adder sequencer: streams NLIMBS 64-bit limbs through an external
// registered carry-select adder, chaining the carry, and presents the full sum.
module mp_add_sequencer #(
  parameter int NLIMBS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [64*NLIMBS-1:0]   in_a,
  input  logic [64*NLIMBS-1:0]   in_b,
  input  logic                   in_cin,
  output logic [63:0]            adder_a,
  output logic [63:0]            adder_b,
  output logic                   adder_cin,
  input  logic [63:0]            adder_sum,
  input  logic                   adder_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [64*NLIMBS-1:0]   out_sum,
  output logic                   out_cout
);

  localparam int W  = 64 * NLIMBS;
  localparam int IW = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

  typedef enum logic [2:0] {IDLE, CIN, OPER, CAPT, DONE} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idx;
  logic [W-1:0]    op_a, op_b;
  logic            op_cin;
  logic [W-1:0]    result;
  logic            carry;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        op_a   <= in_a;
        op_b   <= in_b;
        op_cin <= in_cin;
        idx    <= '0;
      end
      if (state == CAPT) begin
        result[idx*64 +: 64] <= adder_sum;
        carry                <= adder_cout;
        idx                  <= idx + IW'(1);
      end
    end
  end

  // The adder registers its carry one cycle ahead of the operands, so the carry
  // for limb idx is presented in the cycle before that limb (CIN or CAPT).
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    adder_a    = '0;
    adder_b    = '0;
    adder_cin  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CIN;
      end
      CIN: begin
        adder_cin  = op_cin;
        state_next = OPER;
      end
      OPER: begin
        adder_a    = op_a[idx*64 +: 64];
        adder_b    = op_b[idx*64 +: 64];
        state_next = CAPT;
      end
      CAPT: begin
        adder_cin  = adder_cout;
        state_next = (idx < IW'(NLIMBS - 1)) ? OPER : DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_sum  = result;
  assign out_cout = carry;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer with a behavioural registered adder model
// and a scoreboard of expected {cout, sum} pushed on each accepted operand set.
module tb_mp_add_sequencer;

  localparam int NLIMBS = 4;
  localparam int W      = 64 * NLIMBS;
  localparam int LAT    = 2 * NLIMBS + 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a, in_b;
  logic           in_cin;
  logic [63:0]    adder_a, adder_b;
  logic           adder_cin;
  logic [63:0]    adder_sum;
  logic           adder_cout;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout;

  int             errors = 0;
  int             checks = 0;
  int             cycle_cnt = 0;
  int             acc_cycle = 0;
  logic [W:0]     sb[$];

  mp_add_sequencer #(.NLIMBS(NLIMBS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_cin     (in_cin),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cout   (out_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Registered adder: carry is captured one cycle before the operands it joins.
  logic ad_cin_q;
  always @(posedge clk) begin
    if (!rst) begin
      ad_cin_q   <= 1'b0;
      adder_sum  <= '0;
      adder_cout <= 1'b0;
    end else begin
      ad_cin_q                <= adder_cin;
      {adder_cout, adder_sum} <= {1'b0, adder_a} + {1'b0, adder_b} + {64'd0, ad_cin_q};
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input bit expect_immediate);
    int waited;
    waited   = 0;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (expect_immediate) check("accept_first_idle", 512'(waited), 512'd0);
    sb.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
    acc_cycle = cycle_cnt;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = rand_wide();
    in_b     = rand_wide();
    in_cin   = ~c;
  endtask

  task automatic check_output(input string tag, input int stall);
    logic [W:0] exp;
    out_ready = (stall == 0);
    while (!out_valid && (cycle_cnt - acc_cycle) < 60) @(negedge clk);
    check({tag, "_latency"}, 512'(cycle_cnt - acc_cycle), 512'(LAT));
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    check({tag, "_sum"},  512'(out_sum),  512'(exp[W-1:0]));
    check({tag, "_cout"}, 512'(out_cout), 512'(exp[W]));
    check({tag, "_adder_idle"}, 512'({adder_a, adder_b, adder_cin}), 512'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 512'(out_valid), 512'd1);
      check({tag, "_hold_sum"}, 512'({out_cout, out_sum}), 512'(exp));
      check({tag, "_hold_in_ready"}, 512'(in_ready), 512'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_in_ready"}, 512'(in_ready), 512'd1);
    check({tag, "_post_out_valid"}, 512'(out_valid), 512'd0);
  endtask

  initial begin
    logic [W-1:0] ones;
    bit seen_valid;
    ones      = '1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  512'(in_ready),  512'd1);
    check("rst_out_valid", 512'(out_valid), 512'd0);
    check("rst_out_sum",   512'(out_sum),   512'd0);
    check("rst_out_cout",  512'(out_cout),  512'd0);
    check("rst_adder",     512'({adder_a, adder_b, adder_cin}), 512'd0);
    rst = 1'b1;
    @(negedge clk);

    apply_stimulus(W'(5), W'(7), 1'b1, 1'b1);
    check_output("small", 0);

    apply_stimulus(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b1);
    check_output("limb_carry", 0);

    apply_stimulus(ones, '0, 1'b1, 1'b1);
    check_output("wrap", 0);

    for (int k = 0; k < 3; k++) begin
      apply_stimulus(rand_wide(), rand_wide(), 1'($urandom), 1'b1);
      check_output("random", 0);
    end

    apply_stimulus(rand_wide(), rand_wide(), 1'b1, 1'b1);
    check_output("stall", 5);

    apply_stimulus(rand_wide(), rand_wide(), 1'b1, 1'b1);
    while ((cycle_cnt - acc_cycle) < 4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_front());
    check("abort_out_valid", 512'(out_valid), 512'd0);
    check("abort_in_ready",  512'(in_ready),  512'd1);
    check("abort_adder",     512'({adder_a, adder_b, adder_cin}), 512'd0);
    seen_valid = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_result", 512'(seen_valid), 512'd0);

    apply_stimulus(W'(1), W'(2), 1'b0, 1'b1);
    check_output("after_abort", 0);

    apply_stimulus(rand_wide(), rand_wide(), 1'b0, 1'b1);
    in_a     = rand_wide();
    in_b     = rand_wide();
    in_cin   = 1'b1;
    in_valid = 1'b1;
    check_output("b2b_first", 0);
    apply_stimulus(in_a, in_b, in_cin, 1'b1);
    check_output("b2b_second", 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
